// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the sequential AES SubBytes engine: S-box tables,
// FSM state encoding and the byte lookup helper.
// Optional feature macro: SBOX_INV_EN (compiles in the inverse S-box).
package aes_sbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SBOX_INV_EN
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  // Single-byte substitution; inv selects the inverse table when it exists.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
`ifdef SBOX_INV_EN
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
`else
    // Inverse table absent: both modes substitute forward.
    return inv ? SBOX_FWD[b] : SBOX_FWD[b];
`endif
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lookup lane (forward, or inverse when built with
// SBOX_INV_EN and inv = 1).
module sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [7:0] value,
  input  logic       inv,
  output logic [7:0] result
);

  assign result = sbox_lookup(value, inv);

endmodule

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed AES SubBytes engine: substitutes a 128-bit state LANES
// bytes per cycle, in place, with valid/ready handshakes on both sides.
// Optional feature macro: SBOX_INV_EN (inverse substitution via in_inv).
module sub_bytes_seq
  import aes_sbox_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t                          state, state_nxt;
  logic   [CW-1:0]                 cnt;
  // Work register viewed as N groups of LANES bytes; group g holds bytes g*LANES .. g*LANES+LANES-1.
  logic   [N-1:0][LANES*8-1:0]     work, work_nxt;
  logic                            mode, mode_in;
  logic                            accept, last;
  logic   [LANES-1:0][7:0]         lane_in, lane_out;

`ifdef SBOX_INV_EN
  assign mode_in = in_inv;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign mode_in    = 1'b0;
`endif

  assign last     = (cnt == CNT_LAST);
  assign accept   = in_valid && in_ready;
  assign out_data = work;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Select the byte group addressed by cnt for the lanes.
  always_comb begin
    lane_in = work[0];
    for (int g = 0; g < N; g++) begin
      if (cnt == CW'(g)) lane_in = work[g];
    end
  end

  // Write the substituted group back into its own slot.
  always_comb begin
    work_nxt = work;
    for (int g = 0; g < N; g++) begin
      if (cnt == CW'(g)) work_nxt[g] = lane_out;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .value (lane_in[i]),
      .inv   (mode),
      .result(lane_out[i])
    );
  end

  // Work/mode/counter datapath: load on accept, substitute one group per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      work <= in_data;
      mode <= mode_in;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      work <= work_nxt;
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: directed vectors with hand-computed
// results, plus a LANES sweep (1..16) checking data and latency.
module tb_sub_bytes_seq;

  localparam logic [127:0] PAT_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PAT_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ALL63   = {16{8'h63}};
`ifdef SBOX_INV_EN
  localparam logic [127:0] INV63_EXP = 128'h0;
  localparam logic [127:0] RT_IN     = PAT_OUT;
  localparam logic [127:0] RT_EXP    = PAT_IN;
`else
  localparam logic [127:0] INV63_EXP = {16{8'hfb}};
  localparam logic [127:0] RT_IN     = PAT_IN;
  localparam logic [127:0] RT_EXP    = PAT_OUT;
`endif

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  logic         clk, rst, rst_sw;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic         sw_valid;
  logic [127:0] sw_data;
  int           sw_acc;
  logic [4:0]   sw_seen;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bit   prev_valid = 0;
  int   acc_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_seq #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // LANES sweep: one pattern block per lane count, shared stimulus.
  for (genvar i = 0; i < 5; i++) begin : g_sweep
    localparam int L = 1 << i;
    logic         s_ready, s_valid, s_busy;
    logic [127:0] s_data;
    sub_bytes_seq #(.LANES(L)) dut_s (
      .clk(clk), .rst(rst_sw), .in_valid(sw_valid), .in_ready(s_ready),
      .in_data(sw_data), .in_inv(1'b0), .out_valid(s_valid),
      .out_ready(1'b1), .out_data(s_data), .busy(s_busy)
    );
    always @(negedge clk) begin
      #2;
      if (!rst_sw && s_valid && !sw_seen[i]) begin
        sw_seen[i] = 1'b1;
        check($sformatf("sweep_L%0d_data", L), s_data, PAT_OUT);
        check($sformatf("sweep_L%0d_latency", L), 128'(cyc - sw_acc), 128'(16 / L));
      end
    end
    final begin
      if (s_busy === 1'bx || s_ready === 1'bx) $display("sweep L%0d idle flags unknown", L);
    end
  end

  // Monitor: checks latency at the rising out_valid and data on each handshake.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_output: out_valid with no block pending, out_data %h", out_data);
        end else begin
          check("latency", 128'(cyc - sb_q[0].acc), 128'(4));
        end
      end
      if (out_valid && out_ready && sb_q.size() != 0) begin
        check("out_data", out_data, sb_q[0].data);
        void'(sb_q.pop_front());
      end
      prev_valid = out_valid;
    end
  end

  // Present a block and wait (bounded) for its accept; called at a negedge.
  task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp,
                      input bit keep_valid, input bit expect_out);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
    end else begin
      e.data = exp;
      e.acc  = cyc + 1;
      acc_log.push_back(cyc + 1);
      if (expect_out) sb_q.push_back(e);
      @(negedge clk);
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_sw = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
    out_ready = 1'b1; sw_valid = 1'b0; sw_data = '0; sw_acc = 0; sw_seen = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'h0);
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0; rst_sw = 1'b0;
    #1;
    check("release_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    // LANES sweep.
    sw_valid = 1'b1;
    sw_data  = PAT_IN;
    sw_acc   = cyc + 1;
    @(negedge clk);
    sw_valid = 1'b0;
    sw_data  = '0;
    repeat (20) @(negedge clk);
    check("sweep_all_seen", 128'(sw_seen), 128'(5'h1f));

    // Basic vectors.
    send(128'h0, 1'b0, ALL63, 1'b0, 1'b1);
    send(PAT_IN, 1'b0, PAT_OUT, 1'b0, 1'b1);
    send(ALL63, 1'b1, INV63_EXP, 1'b0, 1'b1);
    send(RT_IN, 1'b1, RT_EXP, 1'b0, 1'b1);
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);

    // Backpressure: hold DONE for 5 cycles.
    out_ready = 1'b0;
    send(PAT_IN, 1'b0, PAT_OUT, 1'b0, 1'b1);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", out_data, PAT_OUT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_after", 128'(in_ready), 128'(1));

    // Reset mid-RUN at cnt = 1; the block must vanish.
    send(PAT_IN, 1'b0, PAT_OUT, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_out_valid", 128'(out_valid), 128'(0));
    check("midrun_out_data", out_data, 128'h0);
    check("midrun_busy", 128'(busy), 128'(0));
    check("midrun_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun_release_in_ready", 128'(in_ready), 128'(1));
    repeat (20) @(negedge clk);
    check("midrun_no_stale", out_data, 128'h0);

    // Back-to-back with in_valid held high; in_inv changes between accepts.
    acc_log.delete();
    send(128'h0, 1'b0, ALL63, 1'b1, 1'b1);
    send(ALL63, 1'b1, INV63_EXP, 1'b1, 1'b1);
    send(PAT_IN, 1'b0, PAT_OUT, 1'b1, 1'b1);
    send(RT_IN, 1'b1, RT_EXP, 1'b0, 1'b1);
    if (acc_log.size() == 4) begin
      for (int k = 1; k < 4; k++)
        check("b2b_spacing", 128'(acc_log[k] - acc_log[k-1]), 128'(6));
    end else begin
      checks++;
      errors++;
      $display("FAIL b2b_accepts: got %0d accepts expected 4", acc_log.size());
    end

    for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
    check("drain", 128'(sb_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Parametrised, time-multiplexed AES SubBytes engine that substitutes a full 128-bit state through a configurable number of S-box lanes, with an optional inverse mode. It sits between the round-key adder and ShiftRows in the iterative AES datapath, with valid/ready handshakes on both sides. The parameter trades area against latency: fewer lanes means more cycles per block.

## Interface
- LANES, 4, number of parallel S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  engine can accept a block.
- in_data  in  128  input state; byte k = in_data[8k+7:8k], k = 0..15.
- in_inv  in  1  1 = inverse S-box; sampled only on accept.
- out_valid  out  1  result held on out_data.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  substituted state, same byte mapping as in_data.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - latch in_data into the work register;
  - latch in_inv into the mode register;
  - clear group counter cnt;
  - go to RUN.
- RUN: each cycle, LANES lookups replace bytes cnt*LANES through cnt*LANES+LANES-1 of the work register in place.
  - cnt width is $clog2(16/LANES), minimum 1 bit.
  - At cnt = 16/LANES-1, go to DONE; cnt wraps to 0.
- DONE: out_valid = 1 and out_data = work register, held stable. On out_ready, go to IDLE.
- in_ready = (state == IDLE) && !rst.
  - No accept in RUN or DONE.
  - No combinational path from out_ready to in_ready.
- in_valid/in_data/in_inv changes outside the accept cycle are ignored.
- out_data is the work register directly. Intermediate partially-substituted contents are visible only while out_valid = 0.
- Illegal LANES: $error at elaboration.

## Timing
- Reset values:
  - state IDLE, cnt 0, work register 0, mode 0;
  - out_valid 0, out_data 0, busy 0;
  - in_ready 0 while rst is high, 1 on the first cycle after release.
- Latency: out_valid rises N = 16/LANES cycles after the accepting edge (LANES=16 gives 1, LANES=1 gives 16).
- Minimum block interval: N+2 cycles (accept, N RUN, one DONE cycle with out_ready = 1).
- Backpressure: DONE holds indefinitely. out_data, out_valid = 1 and in_ready = 0 stay stable until out_ready.
- Reset mid-RUN or mid-DONE: immediate return to reset values, and the in-flight block is discarded. No output for it afterwards.
- in_valid held high in DONE with out_ready = 1: the block is accepted on the following IDLE cycle, not the same cycle.

## Configuration
- SBOX_INV_EN defined:
  - the inverse S-box table is compiled in;
  - mode = 1 selects it for all lanes of the block.
- SBOX_INV_EN undefined:
  - the inverse table is absent;
  - in_inv is ignored and mode is forced to 0;
  - forward substitution only.

## Structure
- Package aes_sbox_pkg:
  - 256-entry forward S-box constant array;
  - inverse S-box array, guarded by SBOX_INV_EN;
  - FSM state enum;
  - function sbox_lookup(byte, inv).
- Sub-module sbox_lane: one combinational byte lookup with 8-bit input, inv select and 8-bit output, instantiated LANES times via generate.
- Top level holds the FSM, counter, work/mode registers and per-lane byte muxing.

## Test plan
- Zeros: LANES=4, in_data = 0, in_inv = 0 -> out_data = 0x6363…63 (16 bytes), out_valid 4 cycles after accept.
- Pattern: in_data bytes 15..0 = 00 11 22 33 44 55 66 77 88 99 aa bb cc dd ee ff, forward -> out_data bytes 15..0 = 63 82 93 c3 1b fc 33 f5 c4 ee ac ea 4b c1 28 16, for LANES = 1, 2, 4, 8, 16. Latency 16/8/4/2/1.
- Inverse (SBOX_INV_EN defined): in_data = 0x6363…63, in_inv = 1 -> out_data = 0. Round-trip of a random block returns the original. With the macro undefined, in_inv = 1 gives the forward result.
- Backpressure: out_ready low for 5 cycles in DONE -> out_data/out_valid stable and in_ready 0 throughout. in_ready returns 1 one cycle after the out_ready handshake.
- Reset mid-RUN: assert rst at cnt = 1 (LANES=4) -> out_valid 0, out_data 0, in_ready 1 after release. No stale output appears.
- Back-to-back: in_valid held high with out_ready = 1 -> accepts spaced exactly N+2 cycles apart, and each in_inv latched only at its own accept.
